// File: rtl/mem_read_arbiter.sv
// Two-requester read arbiter for a single synchronous memory read port.
// Grants one read per enabled cycle, tracks each in-flight read (owner + tag)
// in a LATENCY-deep pipeline and steers returned data back to its owner.
module mem_read_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 27,
  parameter int TAG_W   = 32,
  parameter bit RR_EN   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clk_en_i,
  input  logic              flush0_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [TAG_W-1:0]  req0_tag_i,
  output logic              req0_accepted_o,
  output logic              rsp0_valid_o,
  output logic [31:0]       rsp0_data_o,
  output logic [TAG_W-1:0]  rsp0_tag_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [TAG_W-1:0]  req1_tag_i,
  output logic              req1_accepted_o,
  output logic              rsp1_valid_o,
  output logic [31:0]       rsp1_data_o,
  output logic [TAG_W-1:0]  rsp1_tag_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i
);

  logic cand0;
  logic cand1;
  logic grant;
  logic winner;

  logic              lastGrant_q, lastGrant_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;

  logic [LATENCY-1:0]            stgValid_q, stgValid_d;
  logic [LATENCY-1:0]            stgOwner_q, stgOwner_d;
  logic [LATENCY-1:0][TAG_W-1:0] stgTag_q, stgTag_d;

  logic tailValid;
  logic tailOwner;

  // Pick the winner for this cycle and drive the memory address (held when idle)
  always_comb begin
    cand0  = req0_valid_i & clk_en_i & ~rst_i;
    cand1  = req1_valid_i & clk_en_i & ~rst_i;
    grant  = cand0 | cand1;
    winner = 1'b0;
    if (cand0 && cand1) begin
      winner = RR_EN ? ~lastGrant_q : 1'b0;
    end else if (cand1) begin
      winner = 1'b1;
    end
    req0_accepted_o = grant & ~winner;
    req1_accepted_o = grant & winner;
    mem_addr_o      = memAddr_q;
    if (grant) begin
      mem_addr_o = winner ? req1_addr_i : req0_addr_i;
    end
  end

  // Next-state for arbitration history, address hold and the in-flight pipeline
  always_comb begin
    lastGrant_d = grant ? winner : lastGrant_q;
    memAddr_d   = mem_addr_o;
    stgValid_d  = stgValid_q;
    stgOwner_d  = stgOwner_q;
    stgTag_d    = stgTag_q;
    if (clk_en_i) begin
      stgValid_d[0] = grant & ~(flush0_i & ~winner);
      stgOwner_d[0] = winner;
      stgTag_d[0]   = winner ? req1_tag_i : req0_tag_i;
      for (int k = 1; k < LATENCY; k++) begin
        stgValid_d[k] = stgValid_q[k-1] & ~(flush0_i & ~stgOwner_q[k-1]);
        stgOwner_d[k] = stgOwner_q[k-1];
        stgTag_d[k]   = stgTag_q[k-1];
      end
    end
  end

  // State registers; reset discards every in-flight read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGrant_q <= 1'b1;
      memAddr_q   <= '0;
      stgValid_q  <= '0;
      stgOwner_q  <= '0;
      stgTag_q    <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      memAddr_q   <= memAddr_d;
      stgValid_q  <= stgValid_d;
      stgOwner_q  <= stgOwner_d;
      stgTag_q    <= stgTag_d;
    end
  end

  // Route the tail of the pipeline to its owner; a flush hides a returning req0 read
  always_comb begin
    tailValid    = stgValid_q[LATENCY-1] & ~rst_i;
    tailOwner    = stgOwner_q[LATENCY-1];
    rsp0_valid_o = tailValid & ~tailOwner & ~(flush0_i & clk_en_i);
    rsp1_valid_o = tailValid & tailOwner;
    rsp0_data_o  = rsp0_valid_o ? mem_rdata_i : 32'd0;
    rsp0_tag_o   = rsp0_valid_o ? stgTag_q[LATENCY-1] : '0;
    rsp1_data_o  = rsp1_valid_o ? mem_rdata_i : 32'd0;
    rsp1_tag_o   = rsp1_valid_o ? stgTag_q[LATENCY-1] : '0;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares whatever the DUT returns.
module tb_mem_read_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        flush0;
  logic        req0Valid, req1Valid;
  logic [26:0] req0Addr, req1Addr;
  logic [31:0] req0Tag, req1Tag;
  logic        acc0, acc1;
  logic        rsp0Valid, rsp1Valid;
  logic [31:0] rsp0Data, rsp1Data;
  logic [31:0] rsp0Tag, rsp1Tag;
  logic [26:0] memAddr;
  logic [31:0] memRdata;

  logic        fpAcc0, fpAcc1, fpRsp0Valid, fpRsp1Valid;
  logic [31:0] fpRsp0Data, fpRsp1Data, fpRsp0Tag, fpRsp1Tag;
  logic [26:0] fpMemAddr;

  int checks = 0;
  int errors = 0;
  int enCnt  = 0;

  typedef struct {
    logic        owner;
    logic [31:0] tag;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  rsp_t expQ[$];

  logic [31:0] rdPipe [LAT];

  mem_read_arbiter #(.LATENCY(LAT), .ADDR_W(27), .TAG_W(32), .RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .flush0_i(flush0),
    .req0_valid_i(req0Valid), .req0_addr_i(req0Addr), .req0_tag_i(req0Tag),
    .req0_accepted_o(acc0), .rsp0_valid_o(rsp0Valid), .rsp0_data_o(rsp0Data), .rsp0_tag_o(rsp0Tag),
    .req1_valid_i(req1Valid), .req1_addr_i(req1Addr), .req1_tag_i(req1Tag),
    .req1_accepted_o(acc1), .rsp1_valid_o(rsp1Valid), .rsp1_data_o(rsp1Data), .rsp1_tag_o(rsp1Tag),
    .mem_addr_o(memAddr), .mem_rdata_i(memRdata)
  );

  mem_read_arbiter #(.LATENCY(LAT), .ADDR_W(27), .TAG_W(32), .RR_EN(1'b0)) dutFp (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .flush0_i(flush0),
    .req0_valid_i(req0Valid), .req0_addr_i(req0Addr), .req0_tag_i(req0Tag),
    .req0_accepted_o(fpAcc0), .rsp0_valid_o(fpRsp0Valid), .rsp0_data_o(fpRsp0Data), .rsp0_tag_o(fpRsp0Tag),
    .req1_valid_i(req1Valid), .req1_addr_i(req1Addr), .req1_tag_i(req1Tag),
    .req1_accepted_o(fpAcc1), .rsp1_valid_o(fpRsp1Valid), .rsp1_data_o(fpRsp1Data), .rsp1_tag_o(fpRsp1Tag),
    .mem_addr_o(fpMemAddr), .mem_rdata_i(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memFunc(input logic [26:0] a);
    return ({5'd0, a} * 32'h0000_9E37) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous memory model with LAT enabled cycles of read latency
  always @(posedge clk) begin
    if (clk_en) begin
      rdPipe[0] <= memFunc(memAddr);
      for (int k = 1; k < LAT; k++) rdPipe[k] <= rdPipe[k-1];
    end
  end
  assign memRdata = rdPipe[LAT-1];

  // Count enabled, non-reset edges so responses can be checked for exact latency
  always @(posedge clk) begin
    if (clk_en && !rst) enCnt <= enCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; checks grants and queues the expected response
  task automatic applyStimulus(input logic en, input logic fl,
                               input logic v0, input logic [26:0] a0, input logic [31:0] t0,
                               input logic v1, input logic [26:0] a1, input logic [31:0] t1,
                               input logic e0, input logic e1, input logic keep,
                               input logic chkFp, input logic fp1);
    rsp_t r;
    @(posedge clk);
    #1;
    rst = 1'b0; clk_en = en; flush0 = fl;
    req0Valid = v0; req0Addr = a0; req0Tag = t0;
    req1Valid = v1; req1Addr = a1; req1Tag = t1;
    #3;
    checkOutput("req0_accepted", {63'd0, acc0}, {63'd0, e0});
    checkOutput("req1_accepted", {63'd0, acc1}, {63'd0, e1});
    if (chkFp) checkOutput("fixed_prio_req1_accepted", {63'd0, fpAcc1}, {63'd0, fp1});
    if ((e0 || e1) && keep) begin
      r.owner = e1;
      r.tag   = e1 ? t1 : t0;
      r.data  = memFunc(e1 ? a1 : a0);
      r.cyc   = enCnt + LAT;
      expQ.push_back(r);
    end
  endtask

  // Hold reset with both requesters active; nothing may be granted or returned
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1; clk_en = 1'b1; flush0 = 1'b0;
      req0Valid = 1'b1; req0Addr = 27'h7; req0Tag = 32'hEE;
      req1Valid = 1'b1; req1Addr = 27'h8; req1Tag = 32'hEF;
      #3;
      checkOutput("rst_accepted", {62'd0, acc0, acc1}, 64'd0);
      checkOutput("rst_rsp_valid", {62'd0, rsp0Valid, rsp1Valid}, 64'd0);
    end
  endtask

  logic        prevDis = 1'b0;
  logic [97:0] prevSnap = '0;

  // Scoreboard monitor: pops and compares on every enabled, non-reset cycle
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && clk_en) begin
      checkOutput("single_rsp", {63'd0, rsp0Valid & rsp1Valid}, 64'd0);
      if (!rsp0Valid) checkOutput("rsp0_idle_zero", {rsp0Data, rsp0Tag}, 64'd0);
      if (!rsp1Valid) checkOutput("rsp1_idle_zero", {rsp1Data, rsp1Tag}, 64'd0);
      while (expQ.size() > 0 && expQ[0].cyc < enCnt) begin
        checkOutput("rsp_missing", 64'd0, {32'd0, expQ[0].tag});
        void'(expQ.pop_front());
      end
      if (rsp0Valid || rsp1Valid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", {32'd0, rsp1Valid ? rsp1Tag : rsp0Tag}, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_owner", {63'd0, rsp1Valid}, {63'd0, e.owner});
          checkOutput("rsp_tag", {32'd0, rsp1Valid ? rsp1Tag : rsp0Tag}, {32'd0, e.tag});
          checkOutput("rsp_data", {32'd0, rsp1Valid ? rsp1Data : rsp0Data}, {32'd0, e.data});
          checkOutput("rsp_cycle", 64'(enCnt), 64'(e.cyc));
        end
      end
    end
    if (!rst && !clk_en && prevDis) begin
      checkOutput("hold_rsp0", {30'd0, rsp0Valid, rsp0Tag, 1'b0},
                  {30'd0, prevSnap[97], prevSnap[96:65], 1'b0});
      checkOutput("hold_rsp1", {30'd0, rsp1Valid, rsp1Tag, 1'b0},
                  {30'd0, prevSnap[64], prevSnap[63:32], 1'b0});
      checkOutput("hold_data", {32'd0, rsp0Data | rsp1Data}, {32'd0, prevSnap[31:0]});
    end
    prevDis  <= !rst && !clk_en;
    prevSnap <= {rsp0Valid, rsp0Tag, rsp1Valid, rsp1Tag, rsp0Data | rsp1Data};
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; flush0 = 1'b0;
    req0Valid = 1'b0; req0Addr = '0; req0Tag = '0;
    req1Valid = 1'b0; req1Addr = '0; req1Tag = '0;

    doReset(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_mem_addr", {37'd0, memAddr}, 64'd0);

    // Single req0 stream, tags 1..4
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 1, 27'(32'h10 + i), 32'(1 + i), 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // clk_en toggles while req0 keeps requesting
    applyStimulus(1, 0, 1, 27'h20, 32'h21, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 27'h21, 32'h22, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 27'h22, 32'h23, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 27'h22, 32'h23, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 27'h22, 32'h23, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Interleaved reads with a flush0 pulse; req1 tag 0x55 survives
    applyStimulus(1, 0, 1, 27'h30, 32'h31, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 27'h40, 32'h55, 0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 27'h31, 32'h32, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 27'h32, 32'h33, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with two reads in flight; they must never return
    applyStimulus(1, 0, 1, 27'h50, 32'h51, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 27'h60, 32'h61, 0, 1, 0, 0, 0);
    doReset(1);

    // Both requesting right after reset: round-robin starting with req0
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 1, 27'(32'h70 + i), 32'(32'h71 + i), 1, 27'(32'h80 + i), 32'(32'h91 + i),
                    (i % 2) == 0, (i % 2) == 1, 1, 0, 0);

    // Fixed-priority instance never grants req1 while req0 requests
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 1, 27'(32'hA0 + i), 32'(32'hA1 + i), 1, 27'(32'hC0 + i), 32'(32'hC1 + i),
                    (i % 2) == 0, (i % 2) == 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 27'hB0, 32'hB1, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
